// File: rtl/bpm_pkg.sv
// Shared types, widths and interval helpers for the onset BPM estimator.
package bpm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DIVIDE,
      DONE
   } bpm_state_t;

   localparam int unsigned IVL_W = 32;
   localparam int unsigned SUM_W = 34;
   localparam int unsigned NUM_W = 40;

   function automatic longint unsigned ticks_per_beat(
      input longint unsigned clk_freq,
      input longint unsigned tempo
   );
      return (clk_freq * 64'd60) / tempo;
   endfunction

   function automatic longint unsigned min_interval(
      input longint unsigned clk_freq,
      input longint unsigned max_bpm
   );
      return ticks_per_beat(clk_freq, max_bpm);
   endfunction

   function automatic longint unsigned max_interval(
      input longint unsigned clk_freq,
      input longint unsigned min_bpm
   );
      return ticks_per_beat(clk_freq, min_bpm);
   endfunction

endpackage

// File: rtl/bpm_seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
module bpm_seq_divider
   import bpm_pkg::*;
#(
   parameter int unsigned Q_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [NUM_W-1:0] dividend_i,
   input  logic [SUM_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Q_W-1:0]   quot_o
);

   localparam int unsigned CW = (Q_W > 1) ? $clog2(Q_W) : 1;
   localparam int unsigned XW = NUM_W + Q_W;

   logic [NUM_W-1:0] rem_q, rem_d;
   logic [SUM_W-1:0] dvs_q;
   logic [Q_W-1:0]   q_q, q_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [XW-1:0]    trial;

   always_comb begin
      trial = XW'(dvs_q) << cnt_q;
      rem_d = rem_q;
      q_d   = q_q;
      if (XW'(rem_q) >= trial) begin
         rem_d      = rem_q - NUM_W'(trial);
         q_d[cnt_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         rem_q  <= '0;
         dvs_q  <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         rem_q  <= dividend_i;
         dvs_q  <= divisor_i;
         q_q    <= '0;
         cnt_q  <= CW'(Q_W - 1);
      end else if (busy_q) begin
         rem_q <= rem_d;
         q_q   <= q_d;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == '0) begin
            busy_q <= 1'b0;
         end
      end
   end

   // Final bit is resolved combinationally so the result is usable on done.
   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == '0);
   assign quot_o = q_d;

endmodule

// File: rtl/onset_bpm_estimator.sv
// Tempo estimator: onset spacing -> averaged interval -> integer BPM.
// Interval counter runs free of the FSM, which sequences history and divide.
module onset_bpm_estimator
   import bpm_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BPM_WIDTH = 8,
   parameter int unsigned MIN_BPM   = 40,
   parameter int unsigned MAX_BPM   = 240,
   parameter int unsigned AVG_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 onset_detected,
   output logic [BPM_WIDTH-1:0] bpm,
   output logic                 bpm_valid,
   output logic                 locked,
   output logic                 timeout
);

   localparam logic [IVL_W-1:0] MIN_I =
      IVL_W'(min_interval(CLK_FREQ, MAX_BPM));
   localparam logic [IVL_W-1:0] MAX_I =
      IVL_W'(max_interval(CLK_FREQ, MIN_BPM));
   localparam logic [NUM_W-1:0] NUM_K =
      NUM_W'(64'(CLK_FREQ) * 64'd60);
   localparam int unsigned PW =
      (AVG_DEPTH > 1) ? $clog2(AVG_DEPTH) : 1;
   localparam int unsigned NW = $clog2(AVG_DEPTH + 1);
   localparam logic [NW-1:0] N_FULL = NW'(AVG_DEPTH);

   if (64'(MAX_BPM) >= (64'd1 << BPM_WIDTH)) begin : g_bad_max
      $error("MAX_BPM does not fit in BPM_WIDTH");
   end
   if (MIN_I <= IVL_W'(BPM_WIDTH + 3)) begin : g_bad_min
      $error("MIN_INTERVAL too short for divider latency");
   end
   if (AVG_DEPTH == 0 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0) begin : g_bad_avg
      $error("AVG_DEPTH must be a power of two");
   end

   bpm_state_t state_q, state_d;

   logic [IVL_W-1:0]     cnt_q;
   logic [IVL_W-1:0]     interval_q;
   logic                 armed_q;
   logic [IVL_W-1:0]     hist_q [AVG_DEPTH];
   logic [PW-1:0]        wp_q, wp_d;
   logic [SUM_W-1:0]     sum_q, sum_d, old_v;
   logic [NW-1:0]        n_q, n_d;
   logic [BPM_WIDTH-1:0] bpm_q;
   logic                 accept, tmo, full;
   logic                 div_start, div_busy, div_done;
   logic [BPM_WIDTH-1:0] div_quot;
   logic [NUM_W-1:0]     dividend;

   assign accept = onset_detected && armed_q &&
                   (cnt_q >= MIN_I) && (cnt_q <= MAX_I);
   assign tmo    = armed_q && !onset_detected && (cnt_q == MAX_I);

   // Spurious onsets fall through to the increment branch untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         armed_q    <= 1'b0;
         cnt_q      <= '0;
         interval_q <= '0;
      end else if (onset_detected && !armed_q) begin
         armed_q <= 1'b1;
         cnt_q   <= IVL_W'(1);
      end else if (accept) begin
         cnt_q      <= IVL_W'(1);
         interval_q <= cnt_q;
      end else if (tmo) begin
         armed_q <= 1'b0;
      end else if (armed_q) begin
         cnt_q <= cnt_q + IVL_W'(1);
      end
   end

   always_comb begin
      full     = (n_q == N_FULL);
      old_v    = full ? SUM_W'(hist_q[wp_q]) : '0;
      sum_d    = sum_q + SUM_W'(interval_q) - old_v;
      n_d      = full ? n_q : n_q + NW'(1);
      wp_d     = (wp_q == PW'(AVG_DEPTH - 1)) ? '0 : wp_q + PW'(1);
      dividend = NUM_K * NUM_W'(n_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < AVG_DEPTH; i++) begin
            hist_q[i] <= '0;
         end
         wp_q  <= '0;
         sum_q <= '0;
         n_q   <= '0;
      end else if (tmo) begin
         wp_q  <= '0;
         sum_q <= '0;
         n_q   <= '0;
      end else if (state_q == ACCUM) begin
         hist_q[wp_q] <= interval_q;
         wp_q         <= wp_d;
         sum_q        <= sum_d;
         n_q          <= n_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      unique case (state_q)
         IDLE:   if (accept) state_d = ACCUM;
         ACCUM: begin
            div_start = !div_busy;
            state_d   = DIVIDE;
         end
         DIVIDE: if (div_done) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch on the last divide cycle so bpm is visible alongside bpm_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         bpm_q <= '0;
      end else if (state_q == DIVIDE && div_done) begin
         bpm_q <= div_quot;
      end
   end

   bpm_seq_divider #(
      .Q_W(BPM_WIDTH)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .start_i    (div_start),
      .dividend_i (dividend),
      .divisor_i  (sum_d),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (div_quot)
   );

   assign bpm       = bpm_q;
   assign bpm_valid = (state_q == DONE);
   assign locked    = (n_q == N_FULL);
   assign timeout   = tmo;

endmodule

// File: tb/tb_onset_bpm_estimator.sv
// Bench for onset_bpm_estimator: event-level tempo model plus directed scenarios.
module tb_onset_bpm_estimator;

   localparam int CLK_FREQ = 1000;
   localparam int NUM_K    = CLK_FREQ * 60;
   localparam int MIN_IV   = NUM_K / 240;
   localparam int MAX_IV   = NUM_K / 40;
   localparam int DEPTH    = 4;
   localparam int LAT      = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       onset_detected = 1'b0;
   logic [7:0] bpm;
   logic       bpm_valid;
   logic       locked;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   onset_bpm_estimator #(
      .CLK_FREQ  (CLK_FREQ),
      .BPM_WIDTH (8),
      .MIN_BPM   (40),
      .MAX_BPM   (240),
      .AVG_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .onset_detected (onset_detected),
      .bpm            (bpm),
      .bpm_valid      (bpm_valid),
      .locked         (locked),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
      end
   endtask

   // Model: tracks onset times and the accepted-interval window directly.
   int  c = 0;
   bit  started = 0;
   bit  m_armed = 0;
   int  m_last = 0;
   int  m_hist[$];
   int  m_bpm = 0;
   bit  m_locked = 0;
   int  pv_cyc = -1;
   int  pv_val = 0;
   int  pl_cyc = -1;
   bit  pl_val = 0;
   int  m_sum;
   bit  e_valid, e_tmo;

   always @(negedge clk) begin
      if (reset) begin
         m_armed  = 0;
         m_hist.delete();
         m_bpm    = 0;
         m_locked = 0;
         pv_cyc   = -1;
         pl_cyc   = -1;
         started  = 1;
      end else if (started) begin
         if (c == pv_cyc) m_bpm = pv_val;
         if (c == pl_cyc) m_locked = pl_val;
         e_valid = (c == pv_cyc);
         e_tmo = m_armed && !onset_detected && (c - m_last == MAX_IV);
         if (bpm_valid !== e_valid) chk("bpm_valid", int'(bpm_valid), int'(e_valid));
         else checks++;
         if (bpm !== 8'(m_bpm)) chk("bpm", int'(bpm), m_bpm);
         else checks++;
         if (locked !== m_locked) chk("locked", int'(locked), int'(m_locked));
         else checks++;
         if (timeout !== e_tmo) chk("timeout", int'(timeout), int'(e_tmo));
         else checks++;
         if (onset_detected) begin
            if (!m_armed) begin
               m_armed = 1;
               m_last  = c;
            end else if (c - m_last >= MIN_IV) begin
               m_hist.push_back(c - m_last);
               if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
               m_sum = 0;
               foreach (m_hist[i]) m_sum += m_hist[i];
               pv_cyc = c + LAT;
               pv_val = (NUM_K * m_hist.size()) / m_sum;
               pl_cyc = c + 2;
               pl_val = (m_hist.size() == DEPTH);
               m_last = c;
            end
         end else if (e_tmo) begin
            m_armed = 0;
            m_hist.delete();
            pl_cyc = c + 1;
            pl_val = 0;
         end
      end
      c++;
   end

   task automatic tick(input bit o);
      @(posedge clk);
      #1 onset_detected = o;
   endtask

   task automatic beat(input int n);
      repeat (n - 1) tick(0);
      tick(1);
   endtask

   task automatic settle();
      repeat (LAT) tick(0);
      @(negedge clk);
      chk("lit_valid", int'(bpm_valid), 1);
   endtask

   initial begin
      repeat (5) tick(0);
      @(negedge clk);
      chk("rst_bpm", int'(bpm), 0);
      chk("rst_valid", int'(bpm_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_timeout", int'(timeout), 0);
      tick(0);
      reset = 0;

      // Steady 500-cycle beats: 120 BPM, lock after the 5th onset.
      tick(1);
      for (int i = 1; i <= 4; i++) begin
         beat(i == 1 ? 500 : 500 - LAT);
         settle();
         chk("lit_120", int'(bpm), 120);
         chk("lit_lock", int'(locked), int'(i == 4));
      end

      // Window 500,500,500,600 -> 240000/2100.
      for (int i = 0; i < 4; i++) begin
         beat(i == 3 ? 600 - LAT : 500 - LAT);
         settle();
      end
      chk("lit_114", int'(bpm), 114);
      chk("lit_lock114", int'(locked), 1);

      // Restore 500s, then a spurious onset 100 after a beat.
      for (int i = 0; i < 4; i++) begin
         beat(500 - LAT);
         settle();
      end
      chk("lit_120b", int'(bpm), 120);
      beat(100 - LAT);
      repeat (LAT) tick(0);
      @(negedge clk);
      chk("lit_spur", int'(bpm_valid), 0);
      beat(400 - LAT);
      settle();
      chk("lit_120c", int'(bpm), 120);

      // Gap: timeout at +1500, then re-arm and a 400-cycle interval.
      repeat (MAX_IV - LAT) tick(0);
      @(negedge clk);
      chk("lit_tmo", int'(timeout), 1);
      tick(0);
      @(negedge clk);
      chk("lit_unlock", int'(locked), 0);
      chk("lit_hold", int'(bpm), 120);
      repeat (98) tick(0);
      tick(1);
      beat(400);
      settle();
      chk("lit_150", int'(bpm), 150);
      chk("lit_lock150", int'(locked), 0);

      // Reset in the middle of a divide.
      beat(500 - LAT);
      repeat (4) tick(0);
      tick(0);
      reset = 1;
      tick(0);
      reset = 0;
      repeat (LAT) tick(0);
      @(negedge clk);
      chk("lit_abort_bpm", int'(bpm), 0);
      chk("lit_abort_lock", int'(locked), 0);
      tick(1);
      beat(500);
      settle();
      chk("lit_120d", int'(bpm), 120);

      repeat (5) tick(0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
